neo_mc_detector: RTL and testbench
==================================

Name: neo_mc_detector

Overview:
- Parametrised, multi-channel successor to the single-channel NEO block.
- Computes the k-step Nonlinear Energy Operator psi[n] = x[n]^2 - x[n-K]*x[n+K] on time-multiplexed channels.
- Applies a programmable threshold with a per-channel refractory period to flag spikes.
- Sits between the sample front-end (valid/ready stream) and the spike-event consumer.

Parameters:
- N, 16, signed sample width.
- M, 32, signed energy output width; the result saturates to M bits.
- C, 4, number of channels (>=1).
- K, 1, NEO lag (1..4); each channel stores 2K+1 samples.
- REFRACT, 8, number of channel samples suppressed after a spike (0 disables).

Ports:
- Clk, in, 1, system clock, rising edge.
- reset, in, 1, asynchronous active-low reset.
- thresh, in, M, signed spike threshold, sampled at stage 2.
- in_valid, in, 1, input sample valid.
- in_ready, out, 1, block can accept a sample.
- in_chan, in, CW = max(1,$clog2(C)), channel index of in_data.
- in_data, in, N, signed sample.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts the result.
- out_chan, out, CW, channel of the result.
- out_energy, out, M, signed saturated psi for the centre sample x[n-K].
- out_spike, out, 1, threshold crossing outside the refractory period.
- ready, out, 1, all C channels primed (each has received at least 2K+1 samples).

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_chan=0, out_energy=0, out_spike=0, ready=0. All delay lines are cleared, all fill counters and refractory counters are 0, and the pipeline is empty. in_ready=1 once reset deasserts.
- Accept: a sample is accepted when in_valid && in_ready.
- Ready rule: in_ready = ~out_valid | out_ready. The whole pipeline stalls when out_valid && !out_ready.
- Stage 1, on accept:
  - Shift in_data into the delay line of in_chan. Tap 0 is the newest sample; tap 2K is the oldest.
  - Compute sq = tap K squared and pr = tap 0 times tap 2K, both signed 2N-bit, using the post-shift taps.
  - Increment the channel fill counter, saturating at 2K+1.
- Stage 2:
  - d = sq - pr at 2N+1 bits, saturated to the signed M-bit range.
  - spike = (d > thresh, signed) && refr[chan]==0.
  - On spike, refr[chan] <= REFRACT. Otherwise, if refr[chan]!=0, decrement it by 1. The counter changes only on an emitted result for that channel.
- Latency: 2 cycles from accept to out_valid with out_ready held high. Throughput is 1 sample per cycle.
- Warm-up: a result is emitted only when the channel fill count after the shift equals 2K+1. Earlier samples are accepted but produce no output and do not touch refr.
- in_chan >= C: the sample is accepted and discarded with no state change and no output.
- Output hold: out_valid, out_chan, out_energy and out_spike stay stable while out_valid && !out_ready.
- ready: rises one cycle after the last channel reaches a full count. It stays high until reset.
- thresh changes take effect on the next result entering stage 2. There is no glitch on held outputs.
- Reset asserted mid-stream: all state clears immediately and in-flight results are lost. Each channel needs 2K+1 fresh samples before it produces output again.

Decomposition:
- Package neo_pkg:
  - sat_signed(value, width) function.
  - Channel-index width helper.
  - Typedef neo_res_t: struct of chan, energy, spike.
- Sub-module neo_kernel:
  - Per-sample arithmetic: 3 taps in, registered saturated psi out, with a stall enable.
  - The top level owns the channel delay-line array, fill and refractory counters, and the handshake.

Test Plan:
1. Reset state: hold reset=0 for 3 cycles, then release. Check out_valid=0, out_energy=0, out_spike=0, ready=0, in_ready=1.
2. Warm-up and arithmetic (K=1, C=4, M=32, thresh=1000):
   - ch0 fed 1, 2, 3: no output for the first two; the third gives out_chan=0, out_energy=1 (4-3), out_spike=0, 2 cycles after accept.
   - Priming all 4 channels drives ready=1.
3. Saturation (N=16, M=24, K=1): ch0 fed -32768, -32768, 32767 gives out_energy=8388607. Feeding 0, 0, 0 gives 0.
4. Refractory (REFRACT=8, thresh=50, C=1):
   - Constant samples yield 0. Insert an alternating pattern producing energy 400 on 10 consecutive results.
   - Expect out_spike on result 1, 0 on results 2-9, and 1 on result 10.
5. Backpressure: stream 20 samples, with out_ready=0 for 5 cycles mid-stream. Check in_ready=0 during the stall, outputs unchanged, and no lost or duplicated results versus the golden model.
6. Reset mid-operation: after 10 accepted samples, pulse reset low for 1 cycle. Check out_valid drops asynchronously, ready=0, and the next 2 samples per channel give no output.

Source files
------------

// File: rtl/neo_pkg.sv
`timescale 1ns/1ps
// Shared helpers for the multi-channel NEO spike detector: saturation,
// channel-index width and the result record layout.
package neo_pkg;

  localparam int NEO_MAX_CW = 8;
  localparam int NEO_MAX_W  = 64;

  typedef struct packed {
    logic [NEO_MAX_CW-1:0]       chan;
    logic signed [NEO_MAX_W-1:0] energy;
    logic                        spike;
  } neo_res_t;

  function automatic int chan_width(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

  // Clamp a signed value into the signed range of 'width' bits (width < 64).
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int                 width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/neo_kernel.sv
`timescale 1ns/1ps
// Two-stage NEO arithmetic: products of the taps, then saturated difference.
// psi_sat is the combinational stage-2 value, psi_q the held result.
module neo_kernel
  import neo_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld1,
  input  logic                ld2,
  input  logic signed [N-1:0] x0,
  input  logic signed [N-1:0] xk,
  input  logic signed [N-1:0] x2k,
  output logic signed [M-1:0] psi_sat,
  output logic signed [M-1:0] psi_q
);

  localparam int PW = 2 * N;

  logic signed [PW-1:0] sq_q, sq_d;
  logic signed [PW-1:0] pr_q, pr_d;
  logic signed [PW:0]   diff;
  logic signed [M-1:0]  psi_d;

  always_comb begin
    sq_d = sq_q;
    pr_d = pr_q;
    if (ld1) begin
      sq_d = PW'(xk) * PW'(xk);
      pr_d = PW'(x0) * PW'(x2k);
    end
    // One extra bit keeps sq - pr exact before clamping to M bits.
    diff    = (PW + 1)'(sq_q) - (PW + 1)'(pr_q);
    psi_sat = M'(sat_signed(64'(diff), M));
    psi_d   = ld2 ? psi_sat : psi_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq_q  <= '0;
      pr_q  <= '0;
      psi_q <= '0;
    end else begin
      sq_q  <= sq_d;
      pr_q  <= pr_d;
      psi_q <= psi_d;
    end
  end

endmodule

// File: rtl/neo_mc_detector.sv
`timescale 1ns/1ps
// Time-multiplexed k-step NEO spike detector: per-channel delay lines, warm-up
// gating, thresholding with a per-channel refractory period, valid/ready stream.
module neo_mc_detector
  import neo_pkg::*;
#(
  parameter int N       = 16,
  parameter int M       = 32,
  parameter int C       = 4,
  parameter int K       = 1,
  parameter int REFRACT = 8,
  localparam int CW     = chan_width(C)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [M-1:0] thresh,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_chan,
  input  logic signed [N-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_chan,
  output logic signed [M-1:0] out_energy,
  output logic                out_spike,
  output logic                ready
);

  localparam int T  = 2 * K + 1;
  localparam int FW = $clog2(T + 1);
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [FW-1:0] FILL_FULL = FW'(T);
  localparam logic [FW-1:0] FILL_LAST = FW'(T - 1);
  localparam logic [RW-1:0] REFR_LOAD = RW'(REFRACT);

  logic signed [N-1:0] taps_q [C][T];
  logic signed [N-1:0] taps_d [C][T];
  logic [FW-1:0]       fill_q [C];
  logic [FW-1:0]       fill_d [C];
  logic [RW-1:0]       refr_q [C];
  logic [RW-1:0]       refr_d [C];

  logic          s1_valid_q, s1_valid_d;
  logic [CW-1:0] s1_chan_q, s1_chan_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_chan_q, out_chan_d;
  logic          out_spike_q, out_spike_d;
  logic          ready_q, ready_d;

  logic                adv, accept, chan_ok, emit, ld1, ld2, spike;
  logic signed [N-1:0] tap_k, tap_2k;
  logic signed [M-1:0] psi_sat;
  logic [C-1:0]        chan_full;

  assign in_ready = ~out_valid_q | out_ready;
  assign adv      = in_ready;

  generate
    if (C == (1 << CW)) begin : g_chan_pow2
      assign chan_ok = 1'b1;
    end else begin : g_chan_cmp
      assign chan_ok = (in_chan < CW'(C));
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < C; gi++) begin : g_full
      assign chan_full[gi] = (fill_q[gi] == FILL_FULL);
    end
  endgenerate

  always_comb begin
    taps_d = taps_q;
    fill_d = fill_q;
    refr_d = refr_q;
    accept = in_valid && in_ready;
    // Post-shift taps K and 2K are the current taps K-1 and 2K-1.
    tap_k  = taps_q[in_chan][K-1];
    tap_2k = taps_q[in_chan][2*K-1];
    emit   = chan_ok && (fill_q[in_chan] >= FILL_LAST);
    if (accept && chan_ok) begin
      for (int t = T - 1; t > 0; t--) begin
        taps_d[in_chan][t] = taps_q[in_chan][t-1];
      end
      taps_d[in_chan][0] = in_data;
      if (fill_q[in_chan] != FILL_FULL) begin
        fill_d[in_chan] = fill_q[in_chan] + FW'(1);
      end
    end

    ld1        = accept && emit;
    s1_valid_d = adv ? ld1 : s1_valid_q;
    s1_chan_d  = ld1 ? in_chan : s1_chan_q;

    ld2         = adv && s1_valid_q;
    spike       = (psi_sat > thresh) && (refr_q[s1_chan_q] == '0);
    out_valid_d = adv ? s1_valid_q : out_valid_q;
    out_chan_d  = ld2 ? s1_chan_q : out_chan_q;
    out_spike_d = ld2 ? spike : out_spike_q;
    if (ld2) begin
      if (spike) begin
        refr_d[s1_chan_q] = REFR_LOAD;
      end else if (refr_q[s1_chan_q] != '0) begin
        refr_d[s1_chan_q] = refr_q[s1_chan_q] - RW'(1);
      end
    end

    ready_d = ready_q | (&chan_full);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < C; c++) begin
        for (int t = 0; t < T; t++) begin
          taps_q[c][t] <= '0;
        end
        fill_q[c] <= '0;
        refr_q[c] <= '0;
      end
      s1_valid_q  <= 1'b0;
      s1_chan_q   <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_spike_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      taps_q      <= taps_d;
      fill_q      <= fill_d;
      refr_q      <= refr_d;
      s1_valid_q  <= s1_valid_d;
      s1_chan_q   <= s1_chan_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_spike_q <= out_spike_d;
      ready_q     <= ready_d;
    end
  end

  neo_kernel #(.N(N), .M(M)) u_kernel (
    .clk     (clk),
    .reset   (reset),
    .ld1     (ld1),
    .ld2     (ld2),
    .x0      (in_data),
    .xk      (tap_k),
    .x2k     (tap_2k),
    .psi_sat (psi_sat),
    .psi_q   (out_energy)
  );

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_spike = out_spike_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_neo_mc_detector.sv
`timescale 1ns/1ps
// Directed bench for neo_mc_detector (K=1, C=4, M=24): warm-up, arithmetic,
// saturation, refractory suppression, backpressure and mid-stream reset.
module tb_neo_mc_detector;
  import neo_pkg::*;

  localparam int N = 16;
  localparam int M = 24;
  localparam int C = 4;
  localparam int K = 1;
  localparam int REFRACT = 8;
  localparam int SAT_MAX = 8388607;
  localparam int SAT_MIN = -8388608;

  logic                clk = 1'b0;
  logic                reset;
  logic signed [M-1:0] thresh;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_chan;
  logic signed [N-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          out_chan;
  logic signed [M-1:0] out_energy;
  logic                out_spike;
  logic                ready;

  int checks = 0;
  int errors = 0;

  neo_mc_detector #(.N(N), .M(M), .C(C), .K(K), .REFRACT(REFRACT)) dut (
    .clk        (clk),
    .reset      (reset),
    .thresh     (thresh),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_chan    (in_chan),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_chan   (out_chan),
    .out_energy (out_energy),
    .out_spike  (out_spike),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sample with out_ready high; the result (if any) shows two edges later.
  task automatic xfer(input logic [1:0] ch, input int data, input logic exp_v,
                      input int exp_e, input logic exp_s);
    neo_res_t e;
    e.chan   = 8'(ch);
    e.energy = 64'(exp_e);
    e.spike  = exp_s;
    @(negedge clk);
    in_valid = 1'b1;
    in_chan  = ch;
    in_data  = 16'(data);
    #1;
    check("in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check("early_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(exp_v));
    if (exp_v) begin
      check("out_chan", 64'(out_chan), 64'(e.chan));
      check("out_energy", 64'(out_energy), e.energy);
      check("out_spike", 64'(out_spike), 64'(e.spike));
    end
    $display("xfer ch=%0d data=%0d valid=%0b chan=%0d energy=%0d spike=%0b",
             ch, data, out_valid, out_chan, out_energy, out_spike);
  endtask

  initial begin
    int pat [10];
    int exp_e [20];
    int sent;
    int recv;

    reset     = 1'b0;
    thresh    = 24'sd1000;
    in_valid  = 1'b0;
    in_chan   = 2'd0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_ready", 64'(ready), 64'(0));
    reset = 1'b1;
    #1;
    check("rel_out_valid", 64'(out_valid), 64'(0));
    check("rel_out_energy", 64'(out_energy), 64'(0));
    check("rel_out_spike", 64'(out_spike), 64'(0));
    check("rel_out_chan", 64'(out_chan), 64'(0));
    check("rel_ready", 64'(ready), 64'(0));
    check("rel_in_ready", 64'(in_ready), 64'(1));

    // Warm-up and basic arithmetic, thresh = 1000
    xfer(2'd0, 1, 1'b0, 0, 1'b0);
    xfer(2'd0, 2, 1'b0, 0, 1'b0);
    xfer(2'd0, 3, 1'b1, 1, 1'b0);
    xfer(2'd1, 10, 1'b0, 0, 1'b0);
    xfer(2'd1, 20, 1'b0, 0, 1'b0);
    xfer(2'd1, 30, 1'b1, 100, 1'b0);
    xfer(2'd2, 5, 1'b0, 0, 1'b0);
    xfer(2'd2, -5, 1'b0, 0, 1'b0);
    xfer(2'd2, 5, 1'b1, 0, 1'b0);
    xfer(2'd3, 0, 1'b0, 0, 1'b0);
    xfer(2'd3, 40, 1'b0, 0, 1'b0);
    check("ready_before_prime", 64'(ready), 64'(0));
    xfer(2'd3, 0, 1'b1, 1600, 1'b1);
    check("ready_after_prime", 64'(ready), 64'(1));

    // Saturation with M=24, threshold parked at the top of range
    thresh = 24'sh7FFFFF;
    xfer(2'd0, -32768, 1'b1, 65545, 1'b0);
    xfer(2'd0, -32768, 1'b1, SAT_MAX, 1'b0);
    xfer(2'd0, 32767, 1'b1, SAT_MAX, 1'b0);
    xfer(2'd0, 0, 1'b1, SAT_MAX, 1'b0);
    xfer(2'd0, 0, 1'b1, 0, 1'b0);
    xfer(2'd0, 0, 1'b1, 0, 1'b0);
    xfer(2'd1, -32768, 1'b1, 656260, 1'b0);
    xfer(2'd1, 0, 1'b1, SAT_MAX, 1'b0);
    xfer(2'd1, -32768, 1'b1, SAT_MIN, 1'b0);

    // Refractory on ch2, thresh = 50
    thresh = 24'sd50;
    xfer(2'd2, 0, 1'b1, 25, 1'b0);
    xfer(2'd2, 0, 1'b1, 0, 1'b0);
    xfer(2'd2, 0, 1'b1, 0, 1'b0);
    xfer(2'd2, 20, 1'b1, 0, 1'b0);
    pat = '{0, -20, 0, 20, 0, -20, 0, 20, 0, -20};
    for (int i = 0; i < 10; i++) begin
      xfer(2'd2, pat[i], 1'b1, 400, (i == 0) || (i == 9));
    end

    // Backpressure: squares n*n streamed on ch1, stall for 5 cycles
    thresh = 24'sh7FFFFF;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) exp_e[i] = SAT_MAX;
      else if (i == 1) exp_e[i] = 131073;
      else exp_e[i] = 2 * i * i - 1;
    end
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 60 && recv < 20; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 8 && cyc < 13);
      in_valid  = (sent < 20);
      in_chan   = 2'd1;
      in_data   = 16'((sent + 1) * (sent + 1));
      #1;
      if (out_valid) begin
        check("bp_chan", 64'(out_chan), 64'(1));
        check("bp_energy", 64'(out_energy), 64'(exp_e[recv]));
        check("bp_spike", 64'(out_spike), 64'(0));
        if (!out_ready) begin
          check("bp_in_ready", 64'(in_ready), 64'(0));
        end else begin
          $display("stream result %0d energy=%0d", recv, out_energy);
          recv++;
        end
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_sent", 64'(sent), 64'(20));
    check("bp_recv", 64'(recv), 64'(20));
    @(negedge clk);
    @(negedge clk);
    check("bp_drain", 64'(out_valid), 64'(0));

    // Reset asserted while a result is on the output
    thresh = 24'sd1000;
    @(negedge clk);
    in_valid = 1'b1;
    in_chan  = 2'd0;
    in_data  = 16'sd5;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    reset = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'(0));
    check("async_ready", 64'(ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int ch = 0; ch < C; ch++) begin
        xfer(2'(ch), r + 1, 1'b0, 0, 1'b0);
      end
    end
    check("post_rst_ready", 64'(ready), 64'(0));
    xfer(2'd0, 3, 1'b1, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
